// File: rtl/sub_pkg.sv
// Shared encodings and limits for the serial subtractor.
package sub_pkg;
  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/serial_subtractor_full_sub.sv
// 1-bit full subtractor cell built from two half subtractors.
module Half_Subtractor (
  input  logic In_A,
  input  logic In_B,
  output logic Difference,
  output logic Borrow_out
);
  assign Difference = In_A ^ In_B;
  assign Borrow_out = ~In_A & In_B;
endmodule

module Full_Subtractor (
  input  logic In_A,
  input  logic In_B,
  input  logic Borrow_in,
  output logic Difference,
  output logic Borrow_out
);
  logic d1;
  logic b1;
  logic b2;

  Half_Subtractor u_hs0 (
    .In_A       (In_A),
    .In_B       (In_B),
    .Difference (d1),
    .Borrow_out (b1)
  );

  Half_Subtractor u_hs1 (
    .In_A       (d1),
    .In_B       (Borrow_in),
    .Difference (Difference),
    .Borrow_out (b2)
  );

  assign Borrow_out = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor around one Full_Subtractor,
// LSB first, with start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             ovf_o
);
  import sub_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e state_q;
  state_e state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             brw_q;
  logic             bout_q;
  logic             ovf_q;
  logic             a_msb_q;
  logic             b_msb_q;

  logic             fs_diff;
  logic             fs_bout;
  logic [WIDTH:0]   sh_cat;
  logic [WIDTH-1:0] sh_nx;

  Full_Subtractor u_fs (
    .In_A       (a_q[0]),
    .In_B       (b_q[0]),
    .Borrow_in  (brw_q),
    .Difference (fs_diff),
    .Borrow_out (fs_bout)
  );

  // Concatenate then slice so WIDTH=1 needs no special case.
  assign sh_cat = {fs_diff, sh_q};
  assign sh_nx  = sh_cat[WIDTH:1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == LAST) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            brw_q   <= borrow_i;
            cnt_q   <= '0;
            a_msb_q <= a_i[WIDTH-1];
            b_msb_q <= b_i[WIDTH-1];
          end
        end
        ST_SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          sh_q  <= sh_nx;
          brw_q <= fs_bout;
          cnt_q <= cnt_q + CW'(1);
          // Final bit: publish result as we enter DONE.
          if (cnt_q == LAST) begin
            diff_q <= sh_nx;
            bout_q <= fs_bout;
            ovf_q  <= (a_msb_q != b_msb_q) &&
                      (fs_diff != a_msb_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = (state_q == ST_DONE);
  assign diff_o   = diff_q;
  assign borrow_o = bout_q;
  assign ovf_o    = ovf_q;
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor that feeds one Full_Subtractor instance LSB-first, one bit per clock.
- Sits directly upstream of and wraps the Full_Subtractor cell. It supplies operand bits and the registered borrow, and it consumes Difference/Borrow_out into a result shift register.
- Trades WIDTH cycles of latency for a single 1-bit subtractor cell.
- Presents a start/busy/done handshake to the surrounding datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- start_i  input  1  request a new subtraction; sampled only in IDLE.
- a_i  input  WIDTH  minuend; captured when start is accepted.
- b_i  input  WIDTH  subtrahend; captured when start is accepted.
- borrow_i  input  1  initial borrow-in; captured when start is accepted.
- busy_o  output  1  high in SHIFT and DONE states.
- done_o  output  1  one-cycle pulse; result valid.
- diff_o  output  WIDTH  a - b - borrow_i modulo 2^WIDTH.
- borrow_o  output  1  final borrow-out; 1 when a < b + borrow_i (unsigned).
- ovf_o  output  1  signed (two's-complement) overflow of the subtraction.

Behaviour:
- Interface: one clock, clk_i. Reset is synchronous and active-high, on rst_i.
- Reset (rst_i=1 at a rising edge):
  - state to IDLE; busy_o=0, done_o=0.
  - diff_o=0, borrow_o=0, ovf_o=0.
  - Internal shift registers, borrow register and bit counter cleared.
  - Reset asserted mid-operation aborts the operation; no done_o is produced.
- States IDLE, SHIFT, DONE.
- IDLE:
  - If start_i=1, capture a_i, b_i into a_sh, b_sh; borrow_r<=borrow_i; cnt<=0; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (one bit per cycle):
  - Full_Subtractor inputs are In_A=a_sh[0], In_B=b_sh[0], Borrow_in=borrow_r.
  - Each edge: diff_sh <= {Difference, diff_sh[WIDTH-1:1]}; a_sh, b_sh shift right by 1; borrow_r <= Borrow_out; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1, go to DONE.
- DONE (exactly one cycle):
  - done_o=1, with diff_o=diff_sh, borrow_o=borrow_r, ovf_o valid during this cycle.
  - Next edge returns to IDLE.
- Outputs diff_o, borrow_o and ovf_o are registered. They hold their value until the next DONE or reset.
- Overflow rule: ovf_o = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the captured operands.
  - borrow_i participates in the subtraction but is not part of the overflow sign test.
- Latency:
  - start_i sampled at edge E0; WIDTH SHIFT cycles follow.
  - done_o is high in the cycle beginning at edge E0+WIDTH; result available WIDTH+1 cycles after start.
  - Throughput is one operation per WIDTH+2 cycles, because start can only be accepted from IDLE.
- start_i in SHIFT or DONE is ignored: no queuing and no error flag.
  - Operands changing after capture have no effect.
- WIDTH=1: a single SHIFT cycle, then DONE.
- cnt width is $clog2(WIDTH+1), so there is no wrap at WIDTH=32.

Decomposition:
- Shared package (sub_pkg):
  - state encoding ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - MAX_WIDTH=32 constant.
- One sub-module instance: the existing Full_Subtractor (1-bit, built from two Half_Subtractor instances). It is the only arithmetic in the block.
- FSM, counter and shift registers are written inline; no further sub-modules.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, borrow_i=0, start 1 cycle -> busy_o=1 for 9 cycles; done_o pulse on cycle 9 after start; diff_o=0x02, borrow_o=0, ovf_o=0.
- a=0x03, b=0x05, borrow_i=0 -> diff_o=0xFE, borrow_o=1, ovf_o=0. Then a=0x00, b=0x00, borrow_i=1 -> diff_o=0xFF, borrow_o=1.
- a=0x80, b=0x01 -> diff_o=0x7F, borrow_o=0, ovf_o=1. Then a=0x7F, b=0xFF -> diff_o=0x80, borrow_o=1, ovf_o=1.
- Start a=0x10, b=0x01; pulse start_i with a=0xAA during SHIFT and during DONE -> ignored; single done_o, diff_o=0x0F; next start accepted only after busy_o falls.
- Assert rst_i at cycle 4 of SHIFT -> next cycle busy_o=0, diff_o=0, no done_o; a fresh start then completes normally (0x20-0x01 -> 0x1F).
- Bench at WIDTH=1 (1-0 -> 1, borrow 0; 0-1 -> 1, borrow 1, done after 2 cycles) and WIDTH=32 (0x00000000-0x00000001 -> 0xFFFFFFFF, borrow_o=1, done after 33 cycles).
